// File: rtl/fetch_if.sv
// Bundle of fetch-stage control, redirect, program-load and IF/ID output signals.
// The slave modport is the fetch block's view; the master modport is the driving side.
interface fetch_if #(
  parameter int unsigned len     = 32,
  parameter int unsigned NB_addr = 8
);
  logic               enable;
  logic [len-1:0]     in_pc_branch;
  logic               flag_branch;
  logic [len-1:0]     in_pc_jump;
  logic               flag_jump;
  logic [len-1:0]     in_pc_jump_register;
  logic               flag_jump_register;
  logic               stall_flag;
  logic               prog_we;
  logic [NB_addr-1:0] prog_addr;
  logic [len-1:0]     prog_data;
  logic [len-1:0]     out_pc_branch;
  logic [len-1:0]     out_instruccion;
  logic [len-1:0]     out_pc;
  logic               out_halt;
  logic [len-1:0]     out_cycle_count;

  modport master (
    output enable, in_pc_branch, flag_branch, in_pc_jump, flag_jump,
           in_pc_jump_register, flag_jump_register, stall_flag,
           prog_we, prog_addr, prog_data,
    input  out_pc_branch, out_instruccion, out_pc, out_halt, out_cycle_count
  );

  modport slave (
    input  enable, in_pc_branch, flag_branch, in_pc_jump, flag_jump,
           in_pc_jump_register, flag_jump_register, stall_flag,
           prog_we, prog_addr, prog_data,
    output out_pc_branch, out_instruccion, out_pc, out_halt, out_cycle_count
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, writable instruction memory, IF/ID register,
// sticky halt on the all-ones word and an enabled-cycle counter.
module fetch #(
  parameter int unsigned len       = 32,
  parameter int unsigned mem_depth = 256,
  parameter int unsigned NB_addr   = $clog2(mem_depth)
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.slave bus
);

  localparam logic [len-1:0] HALT_WORD = '1;

  logic [len-1:0]     mem_q [mem_depth];
  logic [len-1:0]     pc_q, pc_d;
  logic [len-1:0]     ir_q, ir_d;
  logic [len-1:0]     pcb_q, pcb_d;
  logic [len-1:0]     cnt_q, cnt_d;
  logic               halt_q, halt_d;
  logic [NB_addr-1:0] idx;
  logic [len-1:0]     fetched;
  logic [len-1:0]     pc_plus4;

  // Byte PC; upper bits beyond the memory index are ignored so fetches wrap.
  assign idx      = pc_q[NB_addr+1:2];
  assign fetched  = mem_q[idx];
  assign pc_plus4 = pc_q + len'(4);

  // Program memory is not reset and is writable regardless of enable or halt.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    pcb_d  = pcb_q;
    cnt_d  = cnt_q;
    halt_d = halt_q;
    if (bus.enable && !halt_q) begin
      cnt_d = cnt_q + len'(1);
      if (bus.flag_branch) begin
        pc_d  = bus.in_pc_branch;
        ir_d  = '0;
        pcb_d = '0;
      end else if (bus.stall_flag) begin
        pc_d = pc_q;
      end else if (bus.flag_jump_register) begin
        pc_d  = bus.in_pc_jump_register;
        ir_d  = '0;
        pcb_d = '0;
      end else if (bus.flag_jump) begin
        pc_d  = bus.in_pc_jump;
        ir_d  = '0;
        pcb_d = '0;
      end else if (fetched == HALT_WORD) begin
        halt_d = 1'b1;
        ir_d   = '0;
        pcb_d  = '0;
      end else begin
        pc_d  = pc_plus4;
        ir_d  = fetched;
        pcb_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      ir_q   <= '0;
      pcb_q  <= '0;
      cnt_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      pcb_q  <= pcb_d;
      cnt_q  <= cnt_d;
      halt_q <= halt_d;
    end
  end

  assign bus.out_pc          = pc_q;
  assign bus.out_instruccion = ir_q;
  assign bus.out_pc_branch   = pcb_q;
  assign bus.out_cycle_count = cnt_q;
  assign bus.out_halt        = halt_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch stage.
module tb_fetch;

  logic clk;
  logic reset;

  fetch_if #(.len(32), .NB_addr(8)) bus ();

  fetch #(.len(32), .mem_depth(256), .NB_addr(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Behavioural model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_ir, m_pcb, m_cnt;
  logic        m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc",   bus.out_pc,              m_pc);
    check("ir",   bus.out_instruccion,     m_ir);
    check("pcb",  bus.out_pc_branch,       m_pcb);
    check("halt", 32'(bus.out_halt),       32'(m_halt));
    check("cnt",  bus.out_cycle_count,     m_cnt);
  endtask

  // Apply the fetch rules for one rising edge to the model, then clock and compare.
  task automatic step();
    logic [31:0] w;
    w = m_mem[m_pc[9:2]];
    if (!reset) begin
      m_pc = 0; m_ir = 0; m_pcb = 0; m_cnt = 0; m_halt = 1'b0;
    end else if (bus.enable && !m_halt) begin
      m_cnt = m_cnt + 1;
      if (bus.flag_branch) begin
        m_pc = bus.in_pc_branch; m_ir = 0; m_pcb = 0;
      end else if (bus.stall_flag) begin
        // everything holds
      end else if (bus.flag_jump_register) begin
        m_pc = bus.in_pc_jump_register; m_ir = 0; m_pcb = 0;
      end else if (bus.flag_jump) begin
        m_pc = bus.in_pc_jump; m_ir = 0; m_pcb = 0;
      end else if (w == 32'hFFFF_FFFF) begin
        m_halt = 1'b1; m_ir = 0; m_pcb = 0;
      end else begin
        m_pc  = m_pc + 4;
        m_ir  = w;
        m_pcb = m_pc;
      end
    end
    if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_data;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_ctrl();
    bus.flag_branch = 0; bus.flag_jump = 0; bus.flag_jump_register = 0;
    bus.stall_flag = 0; bus.prog_we = 0;
  endtask

  // Assert reset between edges, check immediate clear, hold one edge, release.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    m_pc = 0; m_ir = 0; m_pcb = 0; m_cnt = 0; m_halt = 1'b0;
    #1;
    check("arst_pc",   bus.out_pc, 32'h0);
    check("arst_ir",   bus.out_instruccion, 32'h0);
    check("arst_pcb",  bus.out_pc_branch, 32'h0);
    check("arst_halt", 32'(bus.out_halt), 32'h0);
    check("arst_cnt",  bus.out_cycle_count, 32'h0);
    step();
    reset = 1'b1;
    bus.prog_we = 0;
  endtask

  logic [31:0] saved_cnt;
  logic [31:0] d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.in_pc_branch = 0; bus.in_pc_jump = 0; bus.in_pc_jump_register = 0;
    bus.prog_addr = 0; bus.prog_data = 0;
    clear_ctrl();
    m_pc = 0; m_ir = 0; m_pcb = 0; m_cnt = 0; m_halt = 1'b0;
    for (int unsigned i = 0; i < 256; i++) m_mem[i] = 32'h0;
    #2;

    // Preload memory under reset with non-halt words, then the directed program.
    for (int unsigned i = 0; i < 256; i++) begin
      d = $urandom();
      if (d == 32'hFFFF_FFFF) d = 32'h1;
      bus.prog_we = 1; bus.prog_addr = 8'(i); bus.prog_data = d;
      step();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      bus.prog_addr = 8'(i); bus.prog_data = 32'h11 * (i + 1);
      step();
    end
    bus.prog_we = 0;
    check("rst_pc",  bus.out_pc, 32'h0);
    check("rst_ir",  bus.out_instruccion, 32'h0);
    check("rst_cnt", bus.out_cycle_count, 32'h0);

    // Sequential fetch
    reset = 1'b1;
    bus.enable = 1'b1;
    step(); check("seq_ir1", bus.out_instruccion, 32'h11); check("seq_pcb1", bus.out_pc_branch, 32'd4);
    step(); check("seq_ir2", bus.out_instruccion, 32'h22); check("seq_pcb2", bus.out_pc_branch, 32'd8);

    // Stall at PC=8 for two cycles
    bus.stall_flag = 1;
    step(); check("stall_pc1", bus.out_pc, 32'd8); check("stall_ir1", bus.out_instruccion, 32'h22);
    step(); check("stall_pc2", bus.out_pc, 32'd8); check("stall_pcb2", bus.out_pc_branch, 32'd8);

    // Branch overrides stall
    bus.flag_branch = 1; bus.in_pc_branch = 32'h40;
    step(); check("br_pc", bus.out_pc, 32'h40); check("br_ir", bus.out_instruccion, 32'h0);
    check("br_pcb", bus.out_pc_branch, 32'h0);
    clear_ctrl();
    step(); check("br_fetch", bus.out_instruccion, m_mem[16]); check("br_pcb2", bus.out_pc_branch, 32'h44);

    // Jump-register beats jump
    bus.flag_jump = 1; bus.in_pc_jump = 32'h20;
    bus.flag_jump_register = 1; bus.in_pc_jump_register = 32'h30;
    step(); check("prio_pc", bus.out_pc, 32'h30); check("prio_ir", bus.out_instruccion, 32'h0);
    clear_ctrl();

    // Enable gating with a program write to mem[5]
    saved_cnt = bus.out_cycle_count;
    bus.enable = 0;
    bus.prog_we = 1; bus.prog_addr = 8'd5; bus.prog_data = 32'hA5A5_0005;
    for (int unsigned i = 0; i < 3; i++) step();
    check("en_pc",  bus.out_pc, 32'h30);
    check("en_cnt", bus.out_cycle_count, saved_cnt);
    bus.prog_we = 0;
    bus.enable = 1;
    bus.flag_jump = 1; bus.in_pc_jump = 32'h14;
    step();
    clear_ctrl();
    step(); check("en_newdata", bus.out_instruccion, 32'hA5A5_0005);
    step(); check("mid_pc", bus.out_pc, 32'h1C);

    // Mid-run async reset, then refetch from address 0
    async_reset();
    step(); check("refetch", bus.out_instruccion, 32'h11);

    // Halt on mem[3]
    bus.prog_we = 1; bus.prog_addr = 8'd3; bus.prog_data = 32'hFFFF_FFFF;
    async_reset();
    for (int unsigned i = 0; i < 4; i++) step();
    check("halt_flag", 32'(bus.out_halt), 32'h1);
    check("halt_pc",   bus.out_pc, 32'd12);
    check("halt_cnt",  bus.out_cycle_count, 32'd4);
    bus.flag_branch = 1; bus.in_pc_branch = 32'h80;
    step(); step();
    check("halt_br_pc",  bus.out_pc, 32'd12);
    check("halt_br_cnt", bus.out_cycle_count, 32'd4);
    clear_ctrl();
    bus.prog_we = 1; bus.prog_addr = 8'd3; bus.prog_data = 32'h33;
    async_reset();

    // Randomized traffic
    for (int unsigned n = 0; n < 1500; n++) begin
      bus.enable             = ($urandom_range(0, 9) != 0);
      bus.flag_branch        = ($urandom_range(0, 11) == 0);
      bus.flag_jump          = ($urandom_range(0, 9) == 0);
      bus.flag_jump_register = ($urandom_range(0, 9) == 0);
      bus.stall_flag         = ($urandom_range(0, 7) == 0);
      bus.in_pc_branch        = $urandom();
      bus.in_pc_jump          = $urandom();
      bus.in_pc_jump_register = $urandom();
      if ($urandom_range(0, 3) != 0) bus.in_pc_branch[31:10] = '0;
      if ($urandom_range(0, 3) != 0) bus.in_pc_jump[31:10] = '0;
      bus.prog_we   = ($urandom_range(0, 5) == 0);
      bus.prog_addr = 8'($urandom());
      bus.prog_data = ($urandom_range(0, 24) == 0) ? 32'hFFFF_FFFF : $urandom();
      if (m_halt && $urandom_range(0, 3) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL expose parameter len, default 32: datapath and instruction width in bits.
REQ-002 The block SHALL expose parameter mem_depth, default 256: instruction memory depth in words.
REQ-003 The block SHALL expose parameter NB_addr, default $clog2(mem_depth): word-index width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  run/step enable; 0 freezes all state.
REQ-007 in_pc_branch  input  len  branch target from execute.
REQ-008 flag_branch  input  1  branch taken.
REQ-009 in_pc_jump  input  len  jump target from decode.
REQ-010 flag_jump  input  1  jump taken.
REQ-011 in_pc_jump_register  input  len  jump-register target from decode.
REQ-012 flag_jump_register  input  1  jump-register taken.
REQ-013 stall_flag  input  1  hazard stall: hold PC and IF/ID.
REQ-014 prog_we  input  1  program-load write enable.
REQ-015 prog_addr  input  NB_addr  program-load word index.
REQ-016 prog_data  input  len  program-load data.
REQ-017 out_pc_branch  output  len  registered PC+4 of the instruction in IF/ID; feeds decode.
REQ-018 out_instruccion  output  len  registered instruction word (IF/ID).
REQ-019 out_pc  output  len  current PC register value.
REQ-020 out_halt  output  1  sticky halt indication.
REQ-021 out_cycle_count  output  len  count of enabled, non-halted cycles.

Function
REQ-022 The PC SHALL be byte-addressed; the memory word index SHALL be pc[NB_addr+1:2], and the upper bits SHALL be ignored (wrap).
REQ-023 Instruction memory SHALL be read combinationally at the PC index; the result SHALL be registered into IF/ID, for a fetch-to-output latency of 1 cycle.
REQ-024 Next-PC priority SHALL be: flag_branch, then stall_flag (hold), then flag_jump_register, then flag_jump, then PC+4.
REQ-025 flag_branch SHALL override stall_flag: PC <= in_pc_branch, and IF/ID SHALL load out_instruccion=0 (NOP) with out_pc_branch=0.
REQ-026 On stall_flag without branch, the PC, out_pc_branch and out_instruccion SHALL hold.
REQ-027 On flag_jump_register or flag_jump (no stall, no branch), the PC SHALL load the respective target, and IF/ID SHALL load NOP with out_pc_branch=0; there is no delay slot.
REQ-028 With no redirect and no stall, out_instruccion SHALL receive mem[index], out_pc_branch SHALL receive PC+4, and the PC SHALL receive PC+4, with modulo 2^len wrap.
REQ-029 A fetched word of 32'hFFFFFFFF with no redirect and no stall SHALL set out_halt at that edge; IF/ID SHALL load NOP, and the PC SHALL NOT advance.
REQ-030 A halt word SHALL be ignored if flag_branch, flag_jump or flag_jump_register is asserted in the same cycle.
REQ-031 While out_halt=1, the PC, IF/ID and out_cycle_count SHALL hold, and redirect inputs SHALL be ignored.
REQ-032 With enable=0, the PC, IF/ID, out_halt and out_cycle_count SHALL hold regardless of the other inputs.
REQ-033 prog_we=1 SHALL write prog_data to mem[prog_addr] at the edge, independent of enable and halt.
REQ-034 A same-cycle write and fetch to one index SHALL return the old data to IF/ID.
REQ-035 out_cycle_count SHALL increment by 1 per edge with enable=1 and out_halt=0, stalls included, and SHALL wrap at 2^len.

Reset
REQ-036 reset=0 SHALL immediately force PC=0, out_pc_branch=0, out_instruccion=0, out_halt=0 and out_cycle_count=0, asynchronously and mid-operation included.
REQ-037 Instruction memory contents SHALL NOT be affected by reset.
REQ-038 Deassertion of reset SHALL take effect at the next rising clk edge; the first fetch SHALL be from address 0.

Verification
REQ-039 Sequential fetch: load mem[0..2]=0x11,0x22,0x33, release reset, enable=1 -> out_instruccion 0x11,0x22,0x33 on cycles 1..3; out_pc_branch 4,8,12.
REQ-040 Stall/branch: stall_flag=1 for 2 cycles at PC=8 -> outputs hold 2 cycles; then flag_branch=1 together with stall_flag=1, target 0x40 -> PC=0x40, IF/ID=NOP, next out_instruccion=mem[16].
REQ-041 Priority: flag_jump=1 (target 0x20) with flag_jump_register=1 (target 0x30) -> PC=0x30, out_instruccion=0.
REQ-042 Halt: mem[3]=0xFFFFFFFF -> out_halt=1 after the 4th edge; PC stays 12; out_cycle_count frozen at 4; later flag_branch has no effect.
REQ-043 Reset mid-run: assert reset=0 between edges at PC=0x1C -> all outputs 0 without a clock edge; memory retains its program, and the refetch after release yields mem[0].
REQ-044 Enable gating: enable=0 for 3 cycles with prog_we writing mem[5] -> PC and out_cycle_count unchanged; with enable=1, mem[5] is fetched with the new data.
